exp_fixed_point_cordic_24_40: RTL and testbench

Computes e^x for a signed 64-bit fixed-point operand in Q24.40 format (1 sign bit, 23 integer bits, 40 fraction bits) and returns e^x in the same format. The block uses range reduction (x = k·ln2 + r), hyperbolic CORDIC in rotation mode on r, then a shift by k. Single-operand iterative datapath with valid/ready handshakes on input and output. It serves as the exponential primitive for the neuron/activation datapath.

---
 rtl/exp_cordic_pkg.sv | 53 +++++
 rtl/exp_cordic_hyp_stage.sv | 32 +++
 rtl/exp_fixed_point_cordic_24_40.sv | 159 +++++++++++++++
 tb/tb_exp_fixed_point_cordic_24_40.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_cordic_pkg.sv
// Shared types and constants for the Q24.40 exponential: ln2 range reduction
// constants, hyperbolic CORDIC gain correction, atanh table and micro-step schedule.
package exp_cordic_pkg;

    localparam int WIDTH    = 64;
    localparam int FRAC     = 40;
    localparam int ITER     = 40;
    localparam int GUARD    = 100;
    localparam logic [5:0] LAST_MICRO = 6'd42;

    typedef logic signed [WIDTH-1:0] q24_40_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_ROTATE,
        ST_SCALE,
        ST_DONE
    } state_e;

    localparam q24_40_t LN2     = 64'sh0000_00B1_7217_F7D2;
    localparam q24_40_t INV_LN2 = 64'sh0000_0171_5476_52B8;
    localparam q24_40_t INV_KH  = 64'sh0000_0135_1E87_200F;
    localparam q24_40_t SAT_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;

    typedef logic [ITER:1][WIDTH-1:0] atanh_tab_t;

    // atanh(t) = sum t^n/n over odd n, summed with GUARD fraction bits then rounded
    function automatic atanh_tab_t gen_atanh();
        atanh_tab_t  tab;
        logic [127:0] acc;
        tab = '0;
        for (int i = 1; i <= ITER; i++) begin
            acc = '0;
            for (int n = 1; i * n <= GUARD; n += 2) begin
                acc = acc + ((128'd1 << (GUARD - i * n)) / 128'(n));
            end
            tab[i] = 64'((acc + (128'd1 << (GUARD - FRAC - 1))) >> (GUARD - FRAC));
        end
        return tab;
    endfunction

    localparam atanh_tab_t ATANH = gen_atanh();

    // Micro-step n (0..42) to shift index; 4, 13 and 40 appear twice.
    function automatic logic [5:0] iter_shift(input logic [5:0] n);
        if (n <= 6'd3) return n + 6'd1;
        else if (n <= 6'd13) return n;
        else if (n <= 6'd41) return n - 6'd1;
        return 6'd40;
    endfunction

endpackage

// File: rtl/exp_cordic_hyp_stage.sv
// One hyperbolic CORDIC micro-rotation in rotation mode, purely combinational.
module exp_cordic_hyp_stage
    import exp_cordic_pkg::*;
(
    input  q24_40_t    x_i,
    input  q24_40_t    y_i,
    input  q24_40_t    z_i,
    input  logic [5:0] shift,
    input  q24_40_t    atanh_i,
    output q24_40_t    x_o,
    output q24_40_t    y_o,
    output q24_40_t    z_o
);

    q24_40_t x_sh;
    q24_40_t y_sh;

    always_comb begin
        x_sh = x_i >>> shift;
        y_sh = y_i >>> shift;
        if (!z_i[WIDTH-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atanh_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atanh_i;
        end
    end

endmodule

// File: rtl/exp_fixed_point_cordic_24_40.sv
// e^x in Q24.40: x = k*ln2 + r, hyperbolic CORDIC gives e^r, result = e^r * 2^k.
module exp_fixed_point_cordic_24_40
    import exp_cordic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x_in,
    input  logic             x_in_valid,
    output logic             x_in_ready,
    output logic [WIDTH-1:0] exp_out,
    output logic             output_valid,
    input  logic             output_ready
);

    function automatic logic signed [7:0] round_k(input logic signed [127:0] p);
        logic signed [127:0] t;
        t = (p + (128'sd1 <<< (2 * FRAC - 1))) >>> (2 * FRAC);
        if (t > 128'sd127) return 8'sd127;
        if (t < -128'sd128) return 8'sh80;
        return t[7:0];
    endfunction

    // Negative m cannot occur for a converged rotation; clamp it so the result stays >= 0.
    function automatic q24_40_t scale_result(input q24_40_t m, input logic signed [7:0] k);
        logic [127:0]      wide;
        logic signed [7:0] neg;
        if (m[WIDTH-1]) return '0;
        if (!k[7]) begin
            if (k >= 8'sd24) return SAT_MAX;
            wide = {64'd0, m} << k[4:0];
            if (wide[127:63] != '0) return SAT_MAX;
            return wide[63:0];
        end
        if (k <= -8'sd64) return '0;
        neg = -k;
        return m >>> neg[5:0];
    endfunction

    state_e            state_q, state_d;
    logic [5:0]        iter_q, iter_d;
    logic              x_in_ready_q, x_in_ready_d;
    logic              output_valid_q, output_valid_d;
    q24_40_t           exp_out_q, exp_out_d;
    q24_40_t           x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [7:0] k_q, k_d;

    logic [5:0]          shift;
    q24_40_t             x_rot, y_rot, z_rot;
    logic signed [127:0] prod_wide;
    logic signed [7:0]   k_new;
    q24_40_t             k_ext;
    q24_40_t             r_new;

    assign shift = iter_shift(iter_q);

    exp_cordic_hyp_stage u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift   (shift),
        .atanh_i (ATANH[shift]),
        .x_o     (x_rot),
        .y_o     (y_rot),
        .z_o     (z_rot)
    );

    always_comb begin
        state_d        = state_q;
        iter_d         = iter_q;
        x_in_ready_d   = x_in_ready_q;
        output_valid_d = output_valid_q;
        exp_out_d      = exp_out_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        k_d            = k_q;

        // z_q holds the operand between acceptance and REDUCE
        prod_wide = {{64{z_q[WIDTH-1]}}, z_q} * {{64{INV_LN2[WIDTH-1]}}, INV_LN2};
        k_new     = round_k(prod_wide);
        k_ext     = {{56{k_new[7]}}, k_new};
        r_new     = z_q - k_ext * LN2;

        case (state_q)
            ST_IDLE: begin
                x_in_ready_d = 1'b1;
                if (x_in_valid && x_in_ready_q) begin
                    z_d          = x_in;
                    x_in_ready_d = 1'b0;
                    state_d      = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                k_d     = k_new;
                x_d     = INV_KH;
                y_d     = '0;
                z_d     = r_new;
                iter_d  = '0;
                state_d = ST_ROTATE;
            end
            ST_ROTATE: begin
                x_d    = x_rot;
                y_d    = y_rot;
                z_d    = z_rot;
                iter_d = iter_q + 6'd1;
                if (iter_q == LAST_MICRO) begin
                    iter_d  = '0;
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                if (iter_q == 6'd0) begin
                    x_d    = x_q + y_q;
                    iter_d = 6'd1;
                end else begin
                    exp_out_d      = scale_result(x_q, k_q);
                    output_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (output_ready) begin
                    output_valid_d = 1'b0;
                    x_in_ready_d   = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            iter_q         <= '0;
            x_in_ready_q   <= 1'b0;
            output_valid_q <= 1'b0;
            exp_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            iter_q         <= iter_d;
            x_in_ready_q   <= x_in_ready_d;
            output_valid_q <= output_valid_d;
            exp_out_q      <= exp_out_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
        k_q <= k_d;
    end

    assign x_in_ready   = x_in_ready_q;
    assign output_valid = output_valid_q;
    assign exp_out      = exp_out_q;

endmodule

// File: tb/tb_exp_fixed_point_cordic_24_40.sv
// Bench for the Q24.40 exponential: reference is real-valued $exp with the stated tolerances.
module tb_exp_fixed_point_cordic_24_40;

    localparam real         LSB_SCALE = 1099511627776.0;
    localparam real         SAT_LIM   = 9223372036854775807.0;
    localparam logic [63:0] SAT_MAX   = 64'h7FFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [63:0] x_in;
    logic        x_in_valid;
    logic        x_in_ready;
    logic [63:0] exp_out;
    logic        output_valid;
    logic        output_ready;

    int n_checks;
    int n_fail;

    logic [63:0] dir_x   [6] = '{64'h0000_0080_0000_0000, 64'h0000_0100_0000_0000,
                                 64'hFFFF_FF80_0000_0000, 64'h0000_0000_0000_0000,
                                 64'h0000_1400_0000_0000, 64'hFFFF_D800_0000_0000};
    real         dir_tol [6] = '{-1.0, -1.0, -1.0, 16.0, -1.0, 2.0};

    exp_fixed_point_cordic_24_40 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x_in         (x_in),
        .x_in_valid   (x_in_valid),
        .x_in_ready   (x_in_ready),
        .exp_out      (exp_out),
        .output_valid (output_valid),
        .output_ready (output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real model_exp(input logic [63:0] x);
        longint xl;
        xl = longint'(x);
        return $exp(real'(xl) / LSB_SCALE) * LSB_SCALE;
    endfunction

    function automatic real model_tol(input real e);
        if (e >= LSB_SCALE) return e / 1073741824.0 + 2.0;
        return 16.0;
    endfunction

    function automatic real as_real(input logic [63:0] v);
        longint vl;
        vl = longint'(v);
        return real'(vl);
    endfunction

    function automatic real absr(input real a);
        return (a < 0.0) ? -a : a;
    endfunction

    // Issue one operand and wait for output_valid; lat = -1 if it never arrives.
    task automatic do_op(input logic [63:0] x, output logic [63:0] res, output int lat);
        int w;
        lat = -1;
        res = '0;
        w   = 0;
        while (!x_in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!x_in_ready) return;
        x_in       = x;
        x_in_valid = 1'b1;
        @(posedge clk); #1;
        x_in_valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (output_valid) begin
                lat = c;
                res = exp_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        x_in         = '0;
        x_in_valid   = 1'b0;
        output_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (x_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_x_in_ready: got %b want 0", x_in_ready);
        end
        n_checks++;
        if (output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_output_valid: got %b want 0", output_valid);
        end
        n_checks++;
        if (exp_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_exp_out: got %h want 0", exp_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (x_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_x_in_ready: got %b want 1", x_in_ready);
        end
    endtask

    task automatic test_directed();
        logic [63:0] res;
        int          lat;
        real         e, tol;
        for (int i = 0; i < 6; i++) begin
            do_op(dir_x[i], res, lat);
            n_checks++;
            if (lat !== 46) begin
                n_fail++;
                $display("FAIL dir_latency x=%h: got %0d want 46", dir_x[i], lat);
            end
            e   = model_exp(dir_x[i]);
            tol = (dir_tol[i] < 0.0) ? model_tol(e) : dir_tol[i];
            n_checks++;
            if (e >= SAT_LIM) begin
                if (res !== SAT_MAX) begin
                    n_fail++;
                    $display("FAIL dir_value x=%h: got %h want %h", dir_x[i], res, SAT_MAX);
                end
            end else if (res[63] || absr(as_real(res) - e) > tol) begin
                n_fail++;
                $display("FAIL dir_value x=%h: got %h want %0.1f (+-%0.1f lsb)", dir_x[i], res, e, tol);
            end
            @(posedge clk); #1;
            n_checks++;
            if (output_valid !== 1'b0 || x_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir_pulse x=%h: got valid=%b ready=%b want valid=0 ready=1",
                         dir_x[i], output_valid, x_in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] x, res;
        longint      xl;
        int          lat;
        real         e, tol;
        for (int i = 0; i < 24; i++) begin
            xl = -(longint'(30) <<< 40)
                 + (longint'($urandom_range(32'd3053453311, 32'd0)) <<< 14)
                 + longint'($urandom_range(32'd16383, 32'd0));
            x = xl;
            do_op(x, res, lat);
            n_checks++;
            if (lat !== 46) begin
                n_fail++;
                $display("FAIL rnd_latency x=%h: got %0d want 46", x, lat);
            end
            e   = model_exp(x);
            tol = model_tol(e);
            n_checks++;
            if (res[63] || absr(as_real(res) - e) > tol) begin
                n_fail++;
                $display("FAIL rnd_value x=%h: got %h want %0.1f (+-%0.1f lsb)", x, res, e, tol);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] res, held;
        int          lat;
        real         e;
        bit          stray;
        output_ready = 1'b0;
        do_op(64'h0000_0300_0000_0000, res, lat);
        n_checks++;
        if (lat !== 46) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d want 46", lat);
        end
        e = model_exp(64'h0000_0300_0000_0000);
        n_checks++;
        if (absr(as_real(res) - e) > model_tol(e)) begin
            n_fail++;
            $display("FAIL bp_value: got %h want %0.1f", res, e);
        end
        held = res;
        for (int c = 0; c < 10; c++) begin
            x_in       = 64'h0000_0200_0000_0000;
            x_in_valid = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (output_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_valid_held cycle %0d: got %b want 1", c, output_valid);
            end
            n_checks++;
            if (exp_out !== held) begin
                n_fail++;
                $display("FAIL bp_exp_stable cycle %0d: got %h want %h", c, exp_out, held);
            end
            n_checks++;
            if (x_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_x_in_ready cycle %0d: got %b want 0", c, x_in_ready);
            end
        end
        x_in_valid   = 1'b0;
        output_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (output_valid !== 1'b0 || x_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1",
                     output_valid, x_in_ready);
        end
        stray = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (output_valid) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_operand: got output_valid=1 want no result");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          lat;
        real         e;
        bit          stray;
        output_ready = 1'b1;
        x_in         = 64'h0000_0200_0000_0000;
        x_in_valid   = 1'b1;
        @(posedge clk); #1;
        x_in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (output_valid !== 1'b0 || exp_out !== 64'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got valid=%b exp=%h want valid=0 exp=0",
                     output_valid, exp_out);
        end
        n_checks++;
        if (x_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_x_in_ready: got %b want 0", x_in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (x_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release_ready: got %b want 1", x_in_ready);
        end
        stray = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (output_valid) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_discard: got output_valid=1 want aborted op discarded");
        end
        do_op(64'h0000_0100_0000_0000, res, lat);
        n_checks++;
        if (lat !== 46) begin
            n_fail++;
            $display("FAIL midrst_latency: got %0d want 46", lat);
        end
        e = model_exp(64'h0000_0100_0000_0000);
        n_checks++;
        if (absr(as_real(res) - e) > model_tol(e)) begin
            n_fail++;
            $display("FAIL midrst_value: got %h want %0.1f", res, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
